tpu_host_loader: RTL and testbench
==================================

# tpu_host_loader

Host-side transmitter for the TPU's byte-wide pin protocol. It takes a load request with weight, input and instruction byte counts, pulls the bytes from a valid/ready source stream, and drives them onto the 8-bit data pins. Each byte is tagged with the 3-bit command code on the flag pins, and the sequence ends with a single start command. It sits on the tester/FPGA side of the chip boundary and produces exactly the command stream the TPU's pin decoder consumes.

## Interface
Parameters:
- GAP_CYCLES, default 1: idle (000) cycles inserted after each non-empty load phase; 0 allowed.
- CNT_W, default 8: width of the byte-count inputs.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset (low = reset).
- go  input  1  start request, sampled only in IDLE.
- n_w  input  CNT_W  number of weight bytes; latched on accepted go.
- n_inp  input  CNT_W  number of input bytes; latched on accepted go.
- n_ins  input  CNT_W  number of instruction bytes; latched on accepted go.
- src_valid  input  1  source byte available.
- src_data  input  8  source byte.
- src_ready  output  1  loader accepts src_data this cycle.
- pin_data  output  8  drives the TPU data pins (ui_in side).
- pin_cmd  output  3  drives the TPU flag pins [7:5]: 000 idle, 001 fetch_w, 010 fetch_inp, 011 fetch_ins, 101 start.
- busy  output  1  high from the cycle after go is accepted until done.
- done  output  1  one-cycle pulse when the sequence completes.

## Operation
- States: IDLE, LOAD_W, LOAD_INP, LOAD_INS, GAP, START, DONE.
- IDLE: when go=1, latch the three counts, set busy, and move to the first phase whose count is non-zero (order W, INP, INS). If all counts are zero, go straight to START.
- LOAD_x: src_ready=1 while the phase's remaining count is >0.
  - On each handshake (src_valid & src_ready): register pin_data<=src_data and pin_cmd<=the phase code, then decrement the remaining count.
  - In a cycle with no handshake: pin_cmd<=000 and pin_data holds its value. The receiver sees a bubble.
- The handshake that accepts the last byte ends the phase. Next state is GAP if GAP_CYCLES>0, otherwise the next non-empty phase, or START.
- GAP: counts GAP_CYCLES cycles with pin_cmd=000, then advances to the next non-empty phase or to START.
- Zero-count phases are skipped entirely and get no GAP.
- START: for exactly one cycle, pin_cmd=101 and pin_data=0x00. Then DONE.
- DONE: done=1 for one cycle, busy deasserts, next state IDLE.
- go while busy: ignored and not queued.
- src_ready is 0 in every state except LOAD_x. Bytes presented outside LOAD_x are not consumed.
- Remaining-count counters are CNT_W bits wide. A phase with count 2^CNT_W-1 must complete with no wrap.

## Timing
- Reset (reset low, asynchronous): state=IDLE, pin_cmd=000, pin_data=0x00, src_ready=0, busy=0, done=0, all counters 0.
- Reset asserted mid-sequence aborts immediately, with the same values as above. Partial loads are not resumed.
- pin_cmd, pin_data, busy and done are registered. src_ready is decoded from the state and the remaining count.
- go sampled at edge 0 → LOAD_W from edge 1, with src_ready high during cycle 1.
- A byte accepted at edge k appears on the pins from edge k+1 for exactly one cycle.
- Back-to-back valid gives one byte per cycle, with no idle cycles inside a phase.
- Timing from the last byte accepted at edge k:
  - Its data is on the pins during cycle k+1.
  - With GAP_CYCLES=G, 000 is on the pins for G cycles.
  - The next phase's src_ready rises on the cycle after the gap ends.
  - After the last phase, 101 appears one cycle after the gap ends.
- done pulses the cycle after the 101 cycle. busy falls on that same edge.
- Minimum total sequence length (all counts 0): go → START → DONE = 3 cycles to done.

## Test plan
- Reset: hold reset low, drive go=1 and src_valid=1 → pins 000/0x00, src_ready=0, busy=0. Assert reset mid-LOAD_INP → outputs at reset values on the same cycle.
- Full sequence: n_w=2, n_inp=1, n_ins=1, GAP_CYCLES=1, source always valid with bytes A1,A2,B1,C1 → pin (cmd,data) sequence is (001,A1),(001,A2),(000,-),(010,B1),(000,-),(011,C1),(000,-),(101,00). done pulses one cycle later.
- Source bubbles: n_w=3, src_valid toggling 1,0,1,0,1 → pin_cmd 001,000,001,000,001, and no bytes are lost or duplicated.
- Zero counts: n_w=0, n_inp=2, n_ins=0 → no 001/011 codes and only one gap. All counts zero → only 101 then done, with src_ready never high.
- go while busy: pulse go again during LOAD_W → ignored; exactly one 101 and one done result.
- Max count: CNT_W=8, n_w=255, continuous valid → exactly 255 cycles of 001, and the counter does not wrap.

Source files
------------

// File: rtl/tpu_host_loader.sv
// Purpose: host-side transmitter that streams weight/input/instruction bytes onto the TPU pin protocol, then issues start.
// Latency: a byte accepted at edge k is on the pins after edge k+1; go at edge 0 gives src_ready in the cycle after edge 0.
// Backpressure: src_ready is high only in a load phase with bytes left; a cycle without src_valid is sent as an idle (000) bubble.
module tpu_host_loader #(
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [CNT_W-1:0] n_w,
  input  logic [CNT_W-1:0] n_inp,
  input  logic [CNT_W-1:0] n_ins,
  input  logic             src_valid,
  input  logic [7:0]       src_data,
  output logic             src_ready,
  output logic [7:0]       pin_data,
  output logic [2:0]       pin_cmd,
  output logic             busy,
  output logic             done
);

  // Gap counter only has to hold 0..GAP_CYCLES-1; keep at least one bit so
  // the GAP_CYCLES=0/1 builds still have a legal vector.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Command codes seen by the TPU pin decoder on ui_in[7:5].
  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_W     = 3'b001;
  localparam logic [2:0] CMD_INP   = 3'b010;
  localparam logic [2:0] CMD_INS   = 3'b011;
  localparam logic [2:0] CMD_START = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_INP,
    S_LOAD_INS,
    S_GAP,
    S_START,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] rem_w;
  logic [CNT_W-1:0] rem_inp;
  logic [CNT_W-1:0] rem_ins;
  logic [GAP_W-1:0] gap_cnt;

  logic [CNT_W-1:0] cur_rem;
  logic [2:0]       cur_code;
  logic             hs;
  logic             last_byte;
  state_t           after_phase;

  // First phase that still has bytes, in W -> INP -> INS order; empty
  // phases are skipped entirely and fall through to START.
  function automatic state_t pick_phase(input logic w_nz,
                                        input logic inp_nz,
                                        input logic ins_nz);
    state_t nxt;
    if (w_nz)        nxt = S_LOAD_W;
    else if (inp_nz) nxt = S_LOAD_INP;
    else if (ins_nz) nxt = S_LOAD_INS;
    else             nxt = S_START;
    return nxt;
  endfunction

  // Decode the active phase: its remaining count, its pin code, and where the
  // sequence goes once the phase's last byte is taken (the current phase is
  // excluded because its counter still reads 1 at that point).
  always_comb begin
    cur_rem     = '0;
    cur_code    = CMD_IDLE;
    after_phase = S_START;
    case (state)
      S_LOAD_W: begin
        cur_rem     = rem_w;
        cur_code    = CMD_W;
        after_phase = pick_phase(1'b0, rem_inp != '0, rem_ins != '0);
      end
      S_LOAD_INP: begin
        cur_rem     = rem_inp;
        cur_code    = CMD_INP;
        after_phase = pick_phase(1'b0, 1'b0, rem_ins != '0);
      end
      S_LOAD_INS: begin
        cur_rem     = rem_ins;
        cur_code    = CMD_INS;
        after_phase = S_START;
      end
      default: begin
        cur_rem     = '0;
        cur_code    = CMD_IDLE;
        after_phase = S_START;
      end
    endcase
    // cur_rem is only non-zero inside a load phase, so this alone keeps
    // src_ready low in every other state.
    src_ready = (cur_rem != '0);
    hs        = src_valid & src_ready;
    last_byte = hs && (cur_rem == CNT_W'(1));
  end

  // Sequencer: owns the state, the per-phase byte counters, the gap counter
  // and every registered pin/status output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      rem_w    <= '0;
      rem_inp  <= '0;
      rem_ins  <= '0;
      gap_cnt  <= '0;
      pin_data <= 8'h00;
      pin_cmd  <= CMD_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          pin_cmd <= CMD_IDLE;
          if (go) begin
            rem_w   <= n_w;
            rem_inp <= n_inp;
            rem_ins <= n_ins;
            busy    <= 1'b1;
            state   <= pick_phase(n_w != '0, n_inp != '0, n_ins != '0);
          end
        end

        S_LOAD_W, S_LOAD_INP, S_LOAD_INS: begin
          if (hs) begin
            pin_data <= src_data;
            pin_cmd  <= cur_code;
            case (state)
              S_LOAD_W:   rem_w   <= rem_w - CNT_W'(1);
              S_LOAD_INP: rem_inp <= rem_inp - CNT_W'(1);
              default:    rem_ins <= rem_ins - CNT_W'(1);
            endcase
            if (last_byte) begin
              gap_cnt <= '0;
              if (GAP_CYCLES > 0) state <= S_GAP;
              else                state <= after_phase;
            end
          end else begin
            // No byte this cycle: the receiver sees an idle bubble while
            // the data pins keep their last value.
            pin_cmd <= CMD_IDLE;
          end
        end

        S_GAP: begin
          pin_cmd <= CMD_IDLE;
          // Finished phases have zero remaining, so the same picker used at
          // go time finds the next phase that still has work.
          if (32'(gap_cnt) >= GAP_CYCLES - 1) begin
            gap_cnt <= '0;
            state   <= pick_phase(rem_w != '0, rem_inp != '0, rem_ins != '0);
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        S_START: begin
          pin_cmd  <= CMD_START;
          pin_data <= 8'h00;
          state    <= S_DONE;
        end

        S_DONE: begin
          pin_cmd <= CMD_IDLE;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          pin_cmd <= CMD_IDLE;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_host_loader.sv
// Purpose: directed self-checking bench for tpu_host_loader with a pin-output scoreboard and per-run command traces.
// Latency: expected (cmd,data) pairs are queued when bytes are staged and popped on every non-idle pin cycle.
// Backpressure: source driver honours src_ready and can insert valid bubbles on alternate busy cycles.
module tb_tpu_host_loader;

  logic       clk;
  logic       reset;
  logic       go;
  logic [7:0] n_w;
  logic [7:0] n_inp;
  logic [7:0] n_ins;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic [7:0] pin_data;
  logic [2:0] pin_cmd;
  logic       busy;
  logic       done;

  tpu_host_loader #(.GAP_CYCLES(1), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .n_w       (n_w),
    .n_inp     (n_inp),
    .n_ins     (n_ins),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .pin_data  (pin_data),
    .pin_cmd   (pin_cmd),
    .busy      (busy),
    .done      (done)
  );

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];      // expected {cmd,data} per non-idle pin cycle
  logic [7:0]  src_q[$];      // bytes the source will offer, in order
  logic [2:0]  trace[$];      // pin_cmd per cycle while monitoring
  logic [2:0]  exp_trace[$];  // expected trace, leading/trailing idles stripped

  int   vld_mode = 0;         // 0: never valid, 1: always valid, 2: valid on alternate busy cycles
  logic mon_en   = 1'b0;
  logic hs_pend  = 1'b0;
  int   done_cnt = 0;
  int   start_cnt = 0;
  logic rdy_seen = 1'b0;
  logic [2:0] prev_cmd = 3'b000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source driver: retire the byte taken at this edge, then present the next one.
  initial begin
    int busy_cyc;
    busy_cyc  = 0;
    src_valid = 1'b0;
    src_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (hs_pend && src_q.size() > 0) void'(src_q.pop_front());
      src_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
      if (busy) begin
        src_valid = (vld_mode == 1) || (vld_mode == 2 && (busy_cyc % 2) == 0);
        busy_cyc++;
      end else begin
        src_valid = (vld_mode == 1);
        busy_cyc  = 0;
      end
    end
  end

  // Monitor: sample away from the active edge, score every non-idle pin cycle.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      hs_pend = src_valid & src_ready;
      if (mon_en) begin
        trace.push_back(pin_cmd);
        if (src_ready) rdy_seen = 1'b1;
        if (pin_cmd == 3'b101) start_cnt++;
        if (done) begin
          done_cnt++;
          chk("done_after_start", 32'(prev_cmd), 32'h5);
          chk("busy_falls_with_done", 32'(busy), 32'h0);
        end
        if (pin_cmd != 3'b000) begin
          if (exp_q.size() == 0) begin
            chk("extra_output", {21'b0, pin_cmd, pin_data}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("pin_out", {21'b0, pin_cmd, pin_data}, {21'b0, e});
          end
        end
        prev_cmd = pin_cmd;
      end
    end
  end

  task automatic stage(input int n, input logic [7:0] base, input logic [2:0] cmd);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      src_q.push_back(b);
      exp_q.push_back({cmd, b});
    end
  endtask

  task automatic tpush(input logic [2:0] cmd, input int n);
    for (int i = 0; i < n; i++) exp_trace.push_back(cmd);
  endtask

  task automatic start_run(input logic [7:0] w, input logic [7:0] inp, input logic [7:0] ins);
    trace.delete();
    done_cnt  = 0;
    start_cnt = 0;
    rdy_seen  = 1'b0;
    mon_en    = 1'b1;
    n_w   = w;
    n_inp = inp;
    n_ins = ins;
    go    = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic check_trace(input string tag);
    int s;
    int e;
    logic ok;
    s = 0;
    e = trace.size();
    while (s < e && trace[s] == 3'b000) s++;
    while (e > s && trace[e-1] == 3'b000) e--;
    ok = ((e - s) == exp_trace.size());
    if (ok) begin
      for (int i = 0; i < exp_trace.size(); i++)
        if (trace[s+i] !== exp_trace[i]) ok = 1'b0;
    end
    chk(tag, 32'(ok), 32'h1);
  endtask

  task automatic finish_run(input string tag, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk({tag, "_done_count"}, 32'(done_cnt), 32'h1);
    chk({tag, "_start_count"}, 32'(start_cnt), 32'h1);
    chk({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'h0);
    check_trace({tag, "_trace"});
    exp_q.delete();
    exp_trace.delete();
  endtask

  initial begin
    int k;
    reset = 1'b0;
    go    = 1'b1;
    n_w   = 8'd3;
    n_inp = 8'd0;
    n_ins = 8'd0;
    vld_mode = 1;

    // Reset held with go and src_valid active.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pin_cmd", 32'(pin_cmd), 32'h0);
    chk("rst_pin_data", 32'(pin_data), 32'h0);
    chk("rst_src_ready", 32'(src_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    go = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full sequence: W=2, INP=1, INS=1, continuous source.
    stage(2, 8'hA1, 3'b001);
    stage(1, 8'hB1, 3'b010);
    stage(1, 8'hC1, 3'b011);
    exp_q.push_back({3'b101, 8'h00});
    tpush(3'b001, 2); tpush(3'b000, 1); tpush(3'b010, 1); tpush(3'b000, 1);
    tpush(3'b011, 1); tpush(3'b000, 1); tpush(3'b101, 1);
    start_run(8'd2, 8'd1, 8'd1);
    chk("full_ready_cycle1", 32'(src_ready), 32'h1);
    chk("full_busy_cycle1", 32'(busy), 32'h1);
    finish_run("full", 200);

    // Source bubbles: valid on alternate cycles during W=3.
    vld_mode = 2;
    stage(3, 8'h10, 3'b001);
    exp_q.push_back({3'b101, 8'h00});
    tpush(3'b001, 1); tpush(3'b000, 1); tpush(3'b001, 1); tpush(3'b000, 1);
    tpush(3'b001, 1); tpush(3'b000, 1); tpush(3'b101, 1);
    start_run(8'd3, 8'd0, 8'd0);
    finish_run("bubbles", 200);
    vld_mode = 1;

    // Only the middle phase has bytes: one gap, no 001/011.
    stage(2, 8'h20, 3'b010);
    exp_q.push_back({3'b101, 8'h00});
    tpush(3'b010, 2); tpush(3'b000, 1); tpush(3'b101, 1);
    start_run(8'd0, 8'd2, 8'd0);
    finish_run("inp_only", 200);

    // All counts zero: start then done with src_ready never raised.
    src_q.push_back(8'h77);
    exp_q.push_back({3'b101, 8'h00});
    tpush(3'b101, 1);
    start_run(8'd0, 8'd0, 8'd0);
    chk("zero_ready_cycle1", 32'(src_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("zero_start_edge1", 32'(pin_cmd), 32'h5);
    @(posedge clk);
    #1;
    chk("zero_done_edge2", 32'(done), 32'h1);
    finish_run("zero", 50);
    chk("zero_ready_never", 32'(rdy_seen), 32'h0);
    chk("zero_byte_not_taken", 32'(src_q.size()), 32'h1);
    src_q.delete();

    // go pulsed again while busy is ignored.
    stage(3, 8'h30, 3'b001);
    exp_q.push_back({3'b101, 8'h00});
    tpush(3'b001, 3); tpush(3'b000, 1); tpush(3'b101, 1);
    start_run(8'd3, 8'd0, 8'd0);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    finish_run("go_busy", 200);
    chk("go_busy_idle_after", 32'(busy), 32'h0);

    // Maximum count: 255 back-to-back weight bytes, no wrap.
    stage(255, 8'h00, 3'b001);
    exp_q.push_back({3'b101, 8'h00});
    tpush(3'b001, 255); tpush(3'b000, 1); tpush(3'b101, 1);
    start_run(8'd255, 8'd0, 8'd0);
    finish_run("max", 600);

    // Reset asserted mid-LOAD_INP aborts at once.
    stage(1, 8'h40, 3'b001);
    stage(4, 8'h50, 3'b010);
    stage(1, 8'h60, 3'b011);
    start_run(8'd1, 8'd4, 8'd1);
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (pin_cmd == 3'b010) break;
      k++;
    end
    chk("abort_in_inp", 32'(pin_cmd), 32'h2);
    chk("abort_ready_before", 32'(src_ready), 32'h1);
    mon_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("abort_pin_cmd", 32'(pin_cmd), 32'h0);
    chk("abort_pin_data", 32'(pin_data), 32'h0);
    chk("abort_src_ready", 32'(src_ready), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", 32'(busy), 32'h0);
    exp_q.delete();
    src_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
